mod_74x161_chain: RTL and testbench

- Behavioural model of N cascaded 74x161 synchronous 4-bit binary counters with the standard ENP/ENT carry-lookahead hookup. Forms one 4*N-bit counter.
- Inter-stage carry gating (ENT of stage k = ENT AND RCO of stage k-1) is the AND function that the quad-AND model provides on the board. This block supplies the per-stage RCO terms that feed those AND gates.
- Used as the address/sequence counter stage directly downstream of the gating logic in the 74xx library.

---
 rtl/mod_74x161_chain.sv | 76 +++++++
 tb/tb_mod_74x161_chain.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mod_74x161_chain.sv
// mod_74x161_chain: N cascaded 74x161 synchronous 4-bit counters with ENP/ENT
// carry lookahead, forming one 4*N-bit counter.
// Ports:
//   CLK        rising-edge clock
//   CLR_n      asynchronous active-low clear of all stages
//   LOAD_n     synchronous active-low parallel load (all stages)
//   ENP        count enable P, common to all stages
//   ENT        count enable T into stage 0, also gates every RCO term
//   D          parallel load data, bit 0 = stage 0 LSB
//   Q          registered counter value
//   RCO_STAGE  per-stage ripple-carry out (combinational on Q and ENT)
//   RCO        terminal count of the whole chain (= RCO_STAGE[N-1])
module mod_74x161_chain #(
  parameter int unsigned N = 2
) (
  input  logic           CLK,
  input  logic           CLR_n,
  input  logic           LOAD_n,
  input  logic           ENP,
  input  logic           ENT,
  input  logic [4*N-1:0] D,
  output logic [4*N-1:0] Q,
  output logic [N-1:0]   RCO_STAGE,
  output logic           RCO
);

  localparam int unsigned W = 4 * N;

  logic [W-1:0] q_r;
  logic [W-1:0] q_next;
  logic [N-1:0] ent_stage;
  logic [N-1:0] rco_stage;

  // Carry lookahead: stage k is enabled when ENT is high and every lower
  // nibble is at terminal count. A running AND avoids a self-referencing
  // vector loop through ent_stage/rco_stage.
  always_comb begin
    logic carry;
    ent_stage = '0;
    rco_stage = '0;
    carry     = ENT;
    for (int unsigned k = 0; k < N; k++) begin
      ent_stage[k] = carry;
      rco_stage[k] = carry && (q_r[4*k +: 4] == 4'hF);
      carry        = rco_stage[k];
    end
  end

  // Next-state per stage: load beats count, count needs ENP and ENT_k.
  always_comb begin
    q_next = q_r;
    if (!LOAD_n) begin
      q_next = D;
    end else if (ENP) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (ent_stage[k]) begin
          q_next[4*k +: 4] = q_r[4*k +: 4] + 4'd1;
        end
      end
    end
  end

  // Counter state; clear is asynchronous and overrides any edge action.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      q_r <= '0;
    end else begin
      q_r <= q_next;
    end
  end

  assign Q         = q_r;
  assign RCO_STAGE = rco_stage;
  assign RCO       = rco_stage[N-1];

endmodule

// File: tb/tb_mod_74x161_chain.sv
module tb_mod_74x161_chain;

  localparam int unsigned N = 2;
  localparam int unsigned W = 4 * N;

  logic           CLK;
  logic           CLR_n;
  logic           LOAD_n;
  logic           ENP;
  logic           ENT;
  logic [W-1:0]   D;
  logic [W-1:0]   Q;
  logic [N-1:0]   RCO_STAGE;
  logic           RCO;

  mod_74x161_chain #(.N(N)) dut (
    .CLK       (CLK),
    .CLR_n     (CLR_n),
    .LOAD_n    (LOAD_n),
    .ENP       (ENP),
    .ENT       (ENT),
    .D         (D),
    .Q         (Q),
    .RCO_STAGE (RCO_STAGE),
    .RCO       (RCO)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [N-1:0] rs;
    logic         rco;
    int           step;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp  = 0;
  int           n_fail = 0;
  int           step   = 0;
  logic [W-1:0] model  = '0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Terminal-count reference: stage k carries when ENT is high and the low
  // 4*(k+1) bits of the counter are all ones.
  function automatic logic [N-1:0] exp_rs(input logic [W-1:0] v, input logic t);
    logic [N-1:0] r;
    logic [63:0]  mask;
    r = '0;
    for (int k = 0; k < N; k++) begin
      mask = (64'd1 << (4 * (k + 1))) - 64'd1;
      r[k] = t && ((64'(v) & mask) == mask);
    end
    return r;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req, input int s);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, s, act, req);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the response
  // expected after the following rising edge.
  task automatic apply(input logic clr, input logic ld, input logic p, input logic t,
                       input logic [W-1:0] d);
    exp_t e;
    @(negedge CLK);
    CLR_n = clr; LOAD_n = ld; ENP = p; ENT = t; D = d;
    step++;
    if (!clr) begin
      model = '0;
      #1;
      cmp("async_clear_q", 64'(Q), 64'(model), step);
      cmp("async_clear_rco", 64'(RCO), 64'(1'b0), step);
    end else if (!ld) begin
      model = d;
    end else if (p && t) begin
      model = model + W'(1);
    end
    e.q    = model;
    e.rs   = exp_rs(model, t);
    e.rco  = e.rs[N-1];
    e.step = step;
    sb.push_back(e);
  endtask

  // Monitor: one output sample per clock, compared against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("q", 64'(Q), 64'(e.q), e.step);
        cmp("rco_stage", 64'(RCO_STAGE), 64'(e.rs), e.step);
        cmp("rco", 64'(RCO), 64'(e.rco), e.step);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    CLR_n = 1'b0; LOAD_n = 1'b1; ENP = 1'b0; ENT = 1'b0; D = '0;
    // Reset state
    apply(0, 1, 0, 0, '0);
    apply(0, 1, 1, 1, '0);
    // Count to 8'h37 then clear mid-count and hold clear across 3 edges
    apply(1, 0, 0, 0, W'(8'h36));
    apply(1, 1, 1, 1, '0);
    apply(0, 1, 1, 1, '0);
    apply(0, 1, 1, 1, '0);
    apply(0, 1, 1, 1, '0);
    // 16 counting edges from zero, crossing the nibble carry
    for (int i = 0; i < 16; i++) apply(1, 1, 1, 1, W'($urandom));
    // Load priority over count
    apply(1, 0, 0, 0, W'(8'h22));
    apply(1, 0, 0, 0, W'(8'hA5));
    apply(1, 0, 1, 1, W'(8'hA5));
    // Terminal count and wrap
    apply(1, 0, 1, 1, W'(8'hFE));
    apply(1, 1, 1, 1, '0);
    apply(1, 1, 1, 1, '0);
    apply(1, 1, 1, 1, '0);
    // Enable gating at all ones
    apply(1, 0, 0, 1, W'(8'hFF));
    apply(1, 1, 1, 0, '0);
    apply(1, 1, 1, 0, '0);
    apply(1, 1, 0, 1, '0);
    apply(1, 1, 0, 1, '0);
    // Clear still low at the edge that would load, then load on the next
    apply(0, 0, 0, 0, W'(8'h55));
    apply(1, 0, 0, 0, W'(8'h55));
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic clr, ld, p, t;
      clr = ($urandom_range(0, 99) >= 3);
      ld  = ($urandom_range(0, 99) >= 10);
      p   = ($urandom_range(0, 99) >= 20);
      t   = ($urandom_range(0, 99) >= 20);
      apply(clr, ld, p, t, ($urandom_range(0, 3) == 0) ? W'(8'hFE) : W'($urandom));
    end
    repeat (3) @(negedge CLK);
    cmp("scoreboard_drained", 64'(sb.size()), 64'd0, step);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
